// File: rtl/rf_pkg.sv
//------------------------------------------------------------------------------
// Module      : rf_pkg
// Description : Shared types and sizing helpers for the register file slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_e;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 3;

   function automatic int rf_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : rf_scoreboard
// Description : Per-register pending-write bits with set/clear/flush and two
//               combinational lookup ports. Bit 0 is permanently clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DEPTH  = rf_depth(RF_ADDR_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en_i,
   input  logic [ADDR_W-1:0] set_addr_i,
   input  logic              clr_en_i,
   input  logic [ADDR_W-1:0] clr_addr_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] lkp_addr_a_i,
   input  logic [ADDR_W-1:0] lkp_addr_b_i,
   output logic              busy_a_o,
   output logic              busy_b_o
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   // Priority: flush beats a new issue, a new issue beats a retiring write.
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) begin
         busy_d[clr_addr_i] = 1'b0;
      end
      if (set_en_i) begin
         busy_d[set_addr_i] = 1'b1;
      end
      if (flush_i) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_a_o = busy_q[lkp_addr_a_i];
   assign busy_b_o = busy_q[lkp_addr_b_i];

endmodule

`default_nettype wire

// File: rtl/param_register_file.sv
//------------------------------------------------------------------------------
// Module      : param_register_file
// Description : 2R/1W register file with r0 hard-wired to zero, busy
//               scoreboard and sequential soft-clear sweep.
//               Optional write-to-read forwarding under macro RF_BYPASS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module param_register_file
   import rf_pkg::*;
#(
   parameter int DATA_W    = RF_DATA_W,
   parameter int ADDR_W    = RF_ADDR_W,
   parameter int CLR_START = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              busy_set_en,
   input  logic [ADDR_W-1:0] busy_set_addr,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              clr_req,
   output logic              clr_busy
);

   localparam int                DEPTH       = rf_depth(ADDR_W);
   localparam logic [ADDR_W-1:0] c_first_idx = ADDR_W'(CLR_START);
   localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(DEPTH - 1);

   rf_state_e         state_q;
   rf_state_e         state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic              w_idle;
   logic              w_wr_fire;
   logic              w_set_fire;
   logic              w_flush;
   logic              w_sb_busy_a;
   logic              w_sb_busy_b;
   logic              w_fwd_a;
   logic              w_fwd_b;

   assign w_idle     = (state_q == RF_IDLE);
   assign w_wr_fire  = w_idle && wr_en && (wr_addr != '0);
   assign w_set_fire = w_idle && busy_set_en && (busy_set_addr != '0);
   assign clr_busy   = (state_q == RF_CLEAR);

   // Sweep control: terminal compare precedes the increment so idx never wraps to r0.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      w_flush = 1'b0;
      case (state_q)
         RF_IDLE: begin
            if (clr_req) begin
               state_d = RF_CLEAR;
               idx_d   = c_first_idx;
               w_flush = 1'b1;
            end
         end
         RF_CLEAR: begin
            if (idx_q == c_last_idx) begin
               state_d = RF_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = RF_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RF_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i] = data_q[i];
      end
      if (w_wr_fire) begin
         data_d[wr_addr] = wr_data;
      end
      if (clr_busy) begin
         data_d[idx_q] = '0;
      end
      data_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .set_en_i     (w_set_fire),
      .set_addr_i   (busy_set_addr),
      .clr_en_i     (w_wr_fire),
      .clr_addr_i   (wr_addr),
      .flush_i      (w_flush),
      .lkp_addr_a_i (rd_addr_a),
      .lkp_addr_b_i (rd_addr_b),
      .busy_a_o     (w_sb_busy_a),
      .busy_b_o     (w_sb_busy_b)
   );

`ifdef RF_BYPASS_EN
   assign w_fwd_a = w_wr_fire && (rd_addr_a == wr_addr);
   assign w_fwd_b = w_wr_fire && (rd_addr_b == wr_addr);
`else
   assign w_fwd_a = 1'b0;
   assign w_fwd_b = 1'b0;
`endif

   // data_q[0] is held at zero, so address 0 needs no special read path.
   assign rd_data_a = w_fwd_a ? wr_data : data_q[rd_addr_a];
   assign rd_data_b = w_fwd_b ? wr_data : data_q[rd_addr_b];
   assign busy_a    = w_fwd_a ? 1'b0 : w_sb_busy_a;
   assign busy_b    = w_fwd_b ? 1'b0 : w_sb_busy_b;

endmodule

`default_nettype wire

// File: tb/tb_param_register_file.sv
//------------------------------------------------------------------------------
// Module      : tb_param_register_file
// Description : Self-checking bench for param_register_file with a reference
//               model; honours RF_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_param_register_file;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int CLR_S = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [AW-1:0] rd_addr_a = '0;
   logic [DW-1:0] rd_data_a;
   logic [AW-1:0] rd_addr_b = '0;
   logic [DW-1:0] rd_data_b;
   logic          busy_set_en = 1'b0;
   logic [AW-1:0] busy_set_addr = '0;
   logic          busy_a;
   logic          busy_b;
   logic          clr_req = 1'b0;
   logic          clr_busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference state: contents, pending bits, and the list of sweep indices still to clear.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_bsy [DEPTH];
   int            m_clear_q [$];

   param_register_file #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .CLR_START (CLR_S)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rd_addr_a     (rd_addr_a),
      .rd_data_a     (rd_data_a),
      .rd_addr_b     (rd_addr_b),
      .rd_data_b     (rd_data_b),
      .busy_set_en   (busy_set_en),
      .busy_set_addr (busy_set_addr),
      .busy_a        (busy_a),
      .busy_b        (busy_b),
      .clr_req       (clr_req),
      .clr_busy      (clr_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = '0;
         m_bsy[i] = 1'b0;
      end
      m_clear_q.delete();
   endtask

   task automatic model_edge();
      if (rst) return;
      if (m_clear_q.size() != 0) begin
         m_mem[m_clear_q.pop_front()] = '0;
      end else begin
         if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr] = wr_data;
            m_bsy[wr_addr] = 1'b0;
         end
         if (busy_set_en && busy_set_addr != 0) m_bsy[busy_set_addr] = 1'b1;
         if (clr_req) begin
            for (int i = 0; i < DEPTH; i++) m_bsy[i] = 1'b0;
            for (int i = CLR_S; i < DEPTH; i++) m_clear_q.push_back(i);
         end
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = (a == 0) ? '0 : m_mem[a];
`ifdef RF_BYPASS_EN
      if (!rst && m_clear_q.size() == 0 && wr_en && wr_addr != 0 && a == wr_addr) v = wr_data;
`endif
      return v;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      logic v;
      v = (a == 0) ? 1'b0 : m_bsy[a];
`ifdef RF_BYPASS_EN
      if (!rst && m_clear_q.size() == 0 && wr_en && wr_addr != 0 && a == wr_addr) v = 1'b0;
`endif
      return v;
   endfunction

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_rd_data_a", 32'(rd_data_a), 32'(exp_data(rd_addr_a)));
         chk("cyc_rd_data_b", 32'(rd_data_b), 32'(exp_data(rd_addr_b)));
         chk("cyc_busy_a", 32'(busy_a), 32'(exp_busy(rd_addr_a)));
         chk("cyc_busy_b", 32'(busy_b), 32'(exp_busy(rd_addr_b)));
         chk("cyc_clr_busy", 32'(clr_busy), 32'(m_clear_q.size() != 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0;
      busy_set_en = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic write(input int a, input logic [DW-1:0] d);
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
      tick();
      idle();
   endtask

   task automatic read(input int a, input int b);
      rd_addr_a = AW'(a);
      rd_addr_b = AW'(b);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      // Reset asserted mid-cycle, all addresses read back as zero.
      #2 rst = 1'b1;
      model_reset();
      chk_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         read(i, DEPTH - 1 - i);
         chk("rst_rd_a", 32'(rd_data_a), 32'h0);
         chk("rst_rd_b", 32'(rd_data_b), 32'h0);
         chk("rst_busy_a", 32'(busy_a), 32'h0);
         chk("rst_busy_b", 32'(busy_b), 32'h0);
         chk("rst_clr_busy", 32'(clr_busy), 32'h0);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      tick();

      write(3, 16'hBEEF);
      read(3, 0);
      chk("wr_r3", 32'(rd_data_a), 32'hBEEF);
      chk("wr_r0_b", 32'(rd_data_b), 32'h0);
      write(0, 16'h1234);
      read(0, 3);
      chk("wr_r0_discard", 32'(rd_data_a), 32'h0);

      busy_set_en = 1'b1; busy_set_addr = 3'd5;
      tick(); idle();
      read(5, 0);
      chk("busy_set_r5", 32'(busy_a), 32'h1);
      write(5, 16'h00AA);
      read(5, 0);
      chk("busy_clr_r5", 32'(busy_a), 32'h0);
      chk("data_r5", 32'(rd_data_a), 32'h00AA);
      busy_set_en = 1'b1; busy_set_addr = 3'd5;
      write(5, 16'h0055);
      read(5, 0);
      chk("same_edge_data", 32'(rd_data_a), 32'h0055);
      chk("same_edge_busy", 32'(busy_a), 32'h1);

      // Soft clear over a filled file, with a write attempted during the sweep.
      for (int i = 1; i < DEPTH; i++) write(i, DW'(16'h1111 * i));
      clr_req = 1'b1;
      tick(); idle();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF;
      read(1, 2);
      chk("sweep_pre_r1", 32'(rd_data_a), 32'h1111);
      cnt = 0;
      while (clr_busy === 1'b1 && cnt < 20) begin
         cnt++;
         if (cnt == 2) begin
            chk("sweep_r1_first", 32'(rd_data_a), 32'h0);
            chk("sweep_r2_kept", 32'(rd_data_b), 32'h2222);
         end
         tick();
      end
      idle();
      chk("sweep_len", 32'(cnt), 32'd7);
      for (int i = 0; i < DEPTH; i++) begin
         read(i, i);
         chk("post_sweep_data", 32'(rd_data_a), 32'h0);
         chk("post_sweep_busy", 32'(busy_b), 32'h0);
      end

      // Reset in the middle of a sweep.
      write(4, 16'h4444);
      clr_req = 1'b1;
      tick(); idle();
      tick(); tick();
      #2 rst = 1'b1;
      model_reset();
      read(4, 7);
      chk("midrst_clr_busy", 32'(clr_busy), 32'h0);
      chk("midrst_r4", 32'(rd_data_a), 32'h0);
      #2 rst = 1'b0;
      write(4, 16'h4444);
      read(4, 0);
      chk("midrst_wr_r4", 32'(rd_data_a), 32'h4444);

      // Forwarding behaviour depends on the build.
      rd_addr_a = 3'd6;
      wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hCAFE;
      #1;
`ifdef RF_BYPASS_EN
      chk("bypass_same_cycle", 32'(rd_data_a), 32'hCAFE);
`else
      chk("nobypass_same_cycle", 32'(rd_data_a), 32'h0);
`endif
      tick(); idle();
      #1;
      chk("bypass_next_cycle", 32'(rd_data_a), 32'hCAFE);

      // Randomised traffic, compared every cycle by the monitor above.
      for (int n = 0; n < 3000; n++) begin
         wr_en         = ($urandom_range(0, 1) == 1);
         wr_addr       = AW'($urandom);
         wr_data       = DW'($urandom);
         rd_addr_a     = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
         rd_addr_b     = AW'($urandom);
         busy_set_en   = ($urandom_range(0, 2) == 0);
         busy_set_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
         clr_req       = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b1;
            model_reset();
            #4 rst = 1'b0;
         end
         tick();
      end
      idle();
      tick();
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised general-purpose register file for the 16-bit Harvard core.
- Two asynchronous read ports, one synchronous write port.
- Register 0 is hard-wired to zero.
- Adds a per-register busy scoreboard for multi-cycle producers (loads, multiply) and a sequential soft-clear sweep.
- Sits between decode (read/issue) and writeback.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers.
- CLR_START, 1, first index cleared by the soft-clear sweep (register 0 is never stored).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write destination.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data.
- busy_set_en  in  1  mark busy_set_addr as pending (issue of a multi-cycle producer).
- busy_set_addr  in  ADDR_W  register to mark pending.
- busy_a  out  1  register at rd_addr_a has a pending write.
- busy_b  out  1  register at rd_addr_b has a pending write.
- clr_req  in  1  pulse: start soft-clear sweep.
- clr_busy  out  1  sweep in progress; the core must stall.

Behaviour:
- Reset (async, rst=1):
  - All registers and busy bits go to 0.
  - FSM goes to IDLE; clr_busy=0.
  - rd_data_a and rd_data_b read 0; busy_a and busy_b are 0.
- Reads: combinational, zero latency.
  - Address 0 always returns 0 with busy=0.
  - Otherwise rd_data returns array[addr] and busy returns busy_bit[addr].
- Write: on the rising edge with wr_en=1, wr_addr!=0 and FSM=IDLE, array[wr_addr] <= wr_data and busy_bit[wr_addr] <= 0. Writes to address 0 are discarded.
- Busy set: on the rising edge with busy_set_en=1, busy_set_addr!=0 and FSM=IDLE, busy_bit[busy_set_addr] <= 1.
- Same-edge write and busy set to the same address: data is written and the busy bit ends at 1 (the new issue wins).
- Write and busy set to different addresses on the same edge: both take effect.
- FSM states:
  - IDLE: clr_req=1 moves to CLEAR; idx <= CLR_START; all busy bits <= 0 on the same edge.
  - CLEAR: each cycle array[idx] <= 0 and idx <= idx+1. When idx == DEPTH-1, that register is cleared and the FSM returns to IDLE.
  - clr_busy = (state==CLEAR). The sweep takes DEPTH-CLR_START cycles (7 at defaults).
- During CLEAR:
  - wr_en and busy_set_en are ignored (dropped, not queued).
  - clr_req is ignored.
  - Reads remain live and return the current, partially cleared contents.
- Reset mid-sweep: immediate return to IDLE with all state zero.
- idx is ADDR_W bits wide. The terminal compare is done before increment, so idx never wraps into register 0.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en=1, wr_addr!=0, FSM=IDLE and rd_addr_x==wr_addr, then rd_data_x=wr_data and busy_x=0 in the same cycle.
- Not defined: reads see the new value only after the clock edge; busy_x reflects the stored bit.
- Forwarding never applies to address 0 or during CLEAR.

Decomposition:
- Package rf_pkg:
  - state enum {RF_IDLE, RF_CLEAR}.
  - Default DATA_W/ADDR_W constants and the DEPTH derivation function.
- Sub-module rf_scoreboard:
  - Holds the DEPTH busy bits with set/clear/flush inputs.
  - Provides two combinational lookup ports.
- The top level holds the data array, the FSM/sweep counter and the bypass muxes.

Test Plan:
- Reset then read: assert rst mid-cycle, read all 8 addresses -> every rd_data=0x0000, busy=0, clr_busy=0.
- Write and read back: write 0xBEEF to r3, then read A=r3, B=r0 -> next cycle rd_data_a=0xBEEF, rd_data_b=0x0000. Write 0x1234 to r0 -> r0 still reads 0.
- Scoreboard:
  - busy_set r5 -> busy_a(r5)=1 next cycle.
  - Write r5=0x00AA -> busy=0, data 0x00AA.
  - Same-edge busy_set r5 and write r5=0x0055 -> data 0x0055, busy=1.
- Soft clear:
  - Fill r1..r7 with 0x1111*i and pulse clr_req -> clr_busy=1 for exactly 7 cycles, with r1 cleared first.
  - A write r2=0xFFFF during the sweep is dropped.
  - Afterwards all registers and busy bits read 0.
- Reset mid-sweep: rst asserted at sweep cycle 3 -> clr_busy=0 immediately; all registers read 0; a write to r4 after reset release succeeds.
- Bypass:
  - With RF_BYPASS_EN defined, write r6=0xCAFE while rd_addr_a=r6 -> rd_data_a=0xCAFE in the same cycle.
  - Without the macro -> old value this cycle, 0xCAFE next cycle.
